// File: rtl/ila_window_capture.sv
`default_nettype none
// ============================================================================
// Module   : ila_window_capture
// Purpose  : ILA capture core. Records probed signals into a circular buffer
//            around a programmable trigger (pre-trigger history plus a
//            post-trigger sample count), then streams the window out oldest
//            sample first as DATA_W-wide ready/valid beats.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i            single clock
//   rst_n_i          synchronous active-low reset
//   cke_i            clock enable, freezes all state when low
//   signal_i         probed data (SIGNAL_W)
//   trigger_i        raw trigger inputs (TRIGGER_W)
//   trigger_mask_i   1 = bit takes part in the reduction
//   trigger_edge_i   1 = rising-edge detect, 0 = level
//   trigger_negate_i inverts the per-bit result
//   reduce_and_i     1 = AND reduction, 0 = OR reduction
//   post_count_i     samples stored after the trigger sample (latched on arm)
//   arm_i / abort_i  start capture / return to idle
//   state_o          0 IDLE, 1 WAIT, 2 POST, 3 READ
//   trig_pos_o       buffer address of the trigger sample
//   n_samples_o      number of valid samples in the window
//   tdata_o/tvalid_o/tready_i/tlast_o  output stream
// ============================================================================
module ila_window_capture #(
  parameter int SIGNAL_W  = 40,
  parameter int TRIGGER_W = 4,
  parameter int DATA_W    = 32,
  parameter int BUFFER_W  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cke_i,
  input  logic [SIGNAL_W-1:0]  signal_i,
  input  logic [TRIGGER_W-1:0] trigger_i,
  input  logic [TRIGGER_W-1:0] trigger_mask_i,
  input  logic [TRIGGER_W-1:0] trigger_edge_i,
  input  logic [TRIGGER_W-1:0] trigger_negate_i,
  input  logic                 reduce_and_i,
  input  logic [BUFFER_W-1:0]  post_count_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  output logic [2:0]           state_o,
  output logic [BUFFER_W-1:0]  trig_pos_o,
  output logic [BUFFER_W:0]    n_samples_o,
  output logic [DATA_W-1:0]    tdata_o,
  output logic                 tvalid_o,
  input  logic                 tready_i,
  output logic                 tlast_o
);

  localparam int c_words  = (SIGNAL_W + DATA_W - 1) / DATA_W;
  localparam int c_depth  = 2 ** BUFFER_W;
  localparam int c_word_w = (c_words > 1) ? $clog2(c_words) : 1;

  localparam logic [2:0] c_idle = 3'd0;
  localparam logic [2:0] c_wait = 3'd1;
  localparam logic [2:0] c_post = 3'd2;
  localparam logic [2:0] c_read = 3'd3;

  localparam logic [BUFFER_W:0]   c_full      = {1'b1, {BUFFER_W{1'b0}}};
  localparam logic [c_word_w-1:0] c_last_word = c_word_w'(c_words - 1);

  logic [2:0]            r_state, w_state_nxt;
  logic [SIGNAL_W-1:0]   r_sig;
  logic [TRIGGER_W-1:0]  r_trig, r_trig_prev;
  logic                  r_skip;
  logic [BUFFER_W-1:0]   r_wr_ptr, r_post, r_trig_pos;
  logic [BUFFER_W:0]     r_cnt;
  logic [SIGNAL_W-1:0]   r_mem [c_depth];

  logic [BUFFER_W-1:0]   r_rd_addr;
  logic [BUFFER_W:0]     r_fetch_left;
  logic [SIGNAL_W-1:0]   r_rd_q;
  logic                  r_rdq_vld;
  logic [SIGNAL_W-1:0]   r_sample;
  logic [c_word_w-1:0]   r_word;
  logic                  r_last_sample;
  logic                  r_tvalid;

  logic [TRIGGER_W-1:0]      w_terms;
  logic                      w_fire_trig, w_hit, w_we, w_arm, w_enter_read;
  logic [BUFFER_W-1:0]       w_wr_ptr_nxt, w_oldest;
  logic [BUFFER_W:0]         w_cnt_nxt;
  logic                      w_beat, w_last_word, w_slot_free, w_load, w_fetch, w_done;
  logic [c_words*DATA_W-1:0] w_padded;

  // Masked-out bits take the reduction identity so they never influence it.
  always_comb begin
    w_terms = '0;
    for (int i = 0; i < TRIGGER_W; i++) begin
      w_terms[i] = trigger_mask_i[i]
                 ? (trigger_negate_i[i] ^ (trigger_edge_i[i] ? (r_trig[i] & ~r_trig_prev[i])
                                                              : r_trig[i]))
                 : reduce_and_i;
    end
  end

  assign w_fire_trig  = reduce_and_i ? (&w_terms) : (|w_terms);
  // r_skip covers the first WAIT cycle, whose registered sample predates the arm.
  assign w_hit        = (r_state == c_wait) & ~r_skip & w_fire_trig;
  assign w_we         = ((r_state == c_wait) & ~r_skip) | (r_state == c_post);
  assign w_arm        = (r_state == c_idle) & arm_i & ~abort_i;
  assign w_wr_ptr_nxt = r_wr_ptr + 1'b1;
  assign w_cnt_nxt    = (r_cnt == c_full) ? r_cnt : r_cnt + 1'b1;
  // Once the buffer has wrapped the oldest sample sits at the write pointer.
  assign w_oldest     = (w_cnt_nxt == c_full) ? w_wr_ptr_nxt : '0;
  assign w_enter_read = (r_state != c_read) & (w_state_nxt == c_read);

  assign w_beat      = r_tvalid & tready_i;
  assign w_last_word = (r_word == c_last_word);
  assign w_slot_free = ~r_tvalid | (w_beat & w_last_word);
  assign w_load      = (r_state == c_read) & w_slot_free & r_rdq_vld;
  // Prefetch one sample ahead so consecutive samples stream without bubbles.
  assign w_fetch     = (r_state == c_read) & (r_fetch_left != '0) & (~r_rdq_vld | w_load);
  assign w_done      = (r_state == c_read) & w_beat & w_last_word & r_last_sample;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)   r_state <= c_idle;
    else if (cke_i) r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (arm_i) w_state_nxt = c_wait;
      c_wait:  if (w_hit) w_state_nxt = (r_post == '0) ? c_read : c_post;
      c_post:  if (r_post == BUFFER_W'(1)) w_state_nxt = c_read;
      c_read:  if (w_done) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
    if (abort_i) w_state_nxt = c_idle;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_padded               = '0;
    w_padded[SIGNAL_W-1:0] = r_sample;
    tdata_o                = '0;
    for (int k = 0; k < c_words; k++) begin
      if (r_word == c_word_w'(k)) tdata_o = w_padded[k*DATA_W +: DATA_W];
    end
    state_o     = r_state;
    tvalid_o    = r_tvalid;
    tlast_o     = r_tvalid & r_last_sample & w_last_word;
    trig_pos_o  = r_trig_pos;
    n_samples_o = r_cnt;
  end

  // ---------------- input stage and capture bookkeeping ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_sig       <= '0;
      r_trig      <= '0;
      r_trig_prev <= '0;
      r_skip      <= 1'b0;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_post      <= '0;
      r_trig_pos  <= '0;
    end else if (cke_i) begin
      r_sig       <= signal_i;
      r_trig      <= trigger_i;
      r_trig_prev <= r_trig;
      r_skip      <= w_arm;
      if (w_arm) begin
        r_wr_ptr <= '0;
        r_cnt    <= '0;
        r_post   <= post_count_i;
      end
      if (w_we) begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_cnt    <= w_cnt_nxt;
      end
      if (w_hit) r_trig_pos <= r_wr_ptr;
      if (r_state == c_post) r_post <= r_post - 1'b1;
    end
  end

  // ---------------- sample buffer (1-cycle registered read) ----------------
  always_ff @(posedge clk_i) begin
    if (rst_n_i && cke_i && w_we) r_mem[r_wr_ptr] <= r_sig;
  end

  always_ff @(posedge clk_i) begin
    if (cke_i && w_fetch) r_rd_q <= r_mem[r_rd_addr];
  end

  // ---------------- readout stream ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rd_addr     <= '0;
      r_fetch_left  <= '0;
      r_rdq_vld     <= 1'b0;
      r_sample      <= '0;
      r_word        <= '0;
      r_last_sample <= 1'b0;
      r_tvalid      <= 1'b0;
    end else if (cke_i) begin
      if (abort_i) begin
        r_fetch_left <= '0;
        r_rdq_vld    <= 1'b0;
        r_tvalid     <= 1'b0;
      end else if (w_enter_read) begin
        r_rd_addr    <= w_oldest;
        r_fetch_left <= w_cnt_nxt;
        r_rdq_vld    <= 1'b0;
        r_tvalid     <= 1'b0;
      end else if (r_state == c_read) begin
        if (w_fetch) begin
          r_rd_addr    <= r_rd_addr + 1'b1;
          r_fetch_left <= r_fetch_left - 1'b1;
          r_rdq_vld    <= 1'b1;
        end else if (w_load) begin
          r_rdq_vld <= 1'b0;
        end
        if (w_load) begin
          r_sample      <= r_rd_q;
          r_word        <= '0;
          r_last_sample <= (r_fetch_left == '0);
          r_tvalid      <= 1'b1;
        end else if (w_beat) begin
          if (!w_last_word) r_word   <= r_word + 1'b1;
          else              r_tvalid <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
